// File: rtl/accum_key_entry_if.sv
// ============================================================================
// Module      : accum_key_entry_if
// Description : Board-side bundle between KEY/SW inputs and the accumulator
//               display outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface accum_key_entry_if #(
  parameter int N = 8
);
  logic         key_n;
  logic         mode;
  logic [N-1:0] d;
  logic [N-1:0] acc;
  logic         carry;
  logic         ovf;
  logic         strobe;

  modport master (
    output key_n, mode, d,
    input  acc, carry, ovf, strobe
  );

  modport slave (
    input  key_n, mode, d,
    output acc, carry, ovf, strobe
  );
endinterface

`default_nettype wire

// File: rtl/accum_key_entry.sv
// ============================================================================
// Module      : accum_key_entry
// Description : Synchronises and debounces an active-low key, then applies one
//               add-with-carry/overflow or load of the switch operand per press.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_key_entry #(
  parameter int N          = 8,
  parameter int DEB_CYCLES = 4
) (
  input  wire logic         Clk,
  input  wire logic         Resetn,
  accum_key_entry_if.slave  bus
);

  localparam int c_CNT_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEB_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_HELD      = 2'd2,
    ST_REL_CHK   = 2'd3
  } state_t;

  logic               r_s1;
  logic               r_s2;
  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               w_apply;

  logic [N-1:0]       r_acc;
  logic               r_carry;
  logic               r_ovf;
  logic               r_strobe;
  logic [N:0]         w_sum;
  logic               w_add_ovf;

  // Two-flop synchroniser; idles high so a released key reads as inactive.
  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
    end else begin
      r_s1 <= bus.key_n;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Any opposite sample in a qualification state restarts from the stable state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_apply     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!r_s2) begin
          w_state_nxt = ST_PRESS_CHK;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      ST_PRESS_CHK: begin
        if (r_s2) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt = ST_HELD;
          w_apply     = 1'b1;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      ST_HELD: begin
        if (r_s2) begin
          w_state_nxt = ST_REL_CHK;
          w_cnt_nxt   = c_CNT_ONE;
        end
      end
      ST_REL_CHK: begin
        if (!r_s2) begin
          w_state_nxt = ST_HELD;
        end else if (r_cnt == c_CNT_MAX) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_cnt_nxt   = r_cnt + c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign w_sum     = {1'b0, r_acc} + {1'b0, bus.d};
  assign w_add_ovf = (r_acc[N-1] == bus.d[N-1]) && (w_sum[N-1] != r_acc[N-1]);

  always_ff @(posedge Clk or negedge Resetn) begin
    if (!Resetn) begin
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
      r_strobe <= 1'b0;
    end else begin
      r_strobe <= w_apply;
      if (w_apply) begin
        if (bus.mode) begin
          r_acc   <= bus.d;
          r_carry <= 1'b0;
          r_ovf   <= 1'b0;
        end else begin
          r_acc   <= w_sum[N-1:0];
          r_carry <= w_sum[N];
          r_ovf   <= w_add_ovf;
        end
      end
    end
  end

  assign bus.acc    = r_acc;
  assign bus.carry  = r_carry;
  assign bus.ovf    = r_ovf;
  assign bus.strobe = r_strobe;

endmodule

`default_nettype wire

// File: tb/tb_accum_key_entry.sv
// ============================================================================
// Module      : tb_accum_key_entry
// Description : Directed, table-driven check of accum_key_entry (N=8, DEB=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_key_entry;

  localparam int c_N   = 8;
  localparam int c_DEB = 4;

  logic clk;
  logic resetn;

  int n_vec;
  int n_err;
  int stb_cnt;
  int stb_edge;
  int edge_no;

  accum_key_entry_if #(.N(c_N)) bus ();

  accum_key_entry #(
    .N          (c_N),
    .DEB_CYCLES (c_DEB)
  ) dut (
    .Clk    (clk),
    .Resetn (resetn),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [7:0] d;
    logic [7:0] acc;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_cnt();
    stb_cnt  = 0;
    stb_edge = 0;
    edge_no  = 0;
  endtask

  // Hold key at lvl for a number of cycles, counting strobe-high cycles.
  task automatic drive(input logic lvl, input int cycles);
    bus.key_n = lvl;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      edge_no++;
      @(negedge clk);
      if (bus.strobe === 1'b1) begin
        stb_cnt++;
        if (stb_edge == 0) stb_edge = edge_no;
      end
    end
  endtask

  initial begin
    clk    = 1'b0;
    resetn = 1'b0;
    n_vec  = 0;
    n_err  = 0;
    bus.key_n = 1'b1;
    bus.mode  = 1'b0;
    bus.d     = '0;
    clear_cnt();

    vecs[0] = '{1'b1, 8'h7F, 8'h7F, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 8'h55, 8'h55, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 8'h2B, 8'h80, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_acc",    int'(bus.acc),    0);
    chk("reset_carry",  int'(bus.carry),  0);
    chk("reset_ovf",    int'(bus.ovf),    0);
    chk("reset_strobe", int'(bus.strobe), 0);
    resetn = 1'b1;
    drive(1'b1, 5);

    foreach (vecs[k]) begin
      bus.mode = vecs[k].mode;
      bus.d    = vecs[k].d;
      clear_cnt();
      drive(1'b0, 20);
      drive(1'b1, 20);
      chk($sformatf("v%0d_strobes", k), stb_cnt, 1);
      chk($sformatf("v%0d_latency", k), stb_edge, c_DEB + 2);
      chk($sformatf("v%0d_acc",     k), int'(bus.acc),   int'(vecs[k].acc));
      chk($sformatf("v%0d_carry",   k), int'(bus.carry), int'(vecs[k].carry));
      chk($sformatf("v%0d_ovf",     k), int'(bus.ovf),   int'(vecs[k].ovf));
    end

    // Press bounce: never qualifies, then a long hold yields one operation.
    bus.mode = 1'b0;
    bus.d    = 8'h10;
    clear_cnt();
    drive(1'b0, 3);
    drive(1'b1, 1);
    drive(1'b0, 3);
    drive(1'b1, 10);
    chk("bounce_strobes", stb_cnt, 0);
    chk("bounce_acc", int'(bus.acc), 'h80);
    drive(1'b0, 100);
    drive(1'b1, 20);
    chk("hold_strobes", stb_cnt, 1);
    chk("hold_acc",     int'(bus.acc),   'h90);
    chk("hold_ovf",     int'(bus.ovf),   0);

    // Release bounce while held: no repeat until a full release.
    bus.d = 8'h01;
    clear_cnt();
    drive(1'b0, 20);
    drive(1'b1, 2);
    drive(1'b0, 20);
    chk("relbounce_strobes", stb_cnt, 1);
    chk("relbounce_acc", int'(bus.acc), 'h91);
    drive(1'b1, 20);
    drive(1'b0, 20);
    drive(1'b1, 20);
    chk("repress_strobes", stb_cnt, 2);
    chk("repress_acc", int'(bus.acc), 'h92);

    // Reset in the middle of press qualification.
    bus.mode = 1'b1;
    bus.d    = 8'h55;
    drive(1'b0, 20);
    drive(1'b1, 20);
    chk("preload_acc", int'(bus.acc), 'h55);
    bus.mode = 1'b0;
    bus.d    = 8'h03;
    clear_cnt();
    drive(1'b0, 4);
    resetn = 1'b0;
    #1;
    chk("midreset_acc",    int'(bus.acc),    0);
    chk("midreset_strobe", int'(bus.strobe), 0);
    drive(1'b0, 3);
    chk("midreset_strobes", stb_cnt, 0);
    resetn = 1'b1;
    clear_cnt();
    drive(1'b0, 20);
    drive(1'b1, 20);
    chk("postreset_strobes", stb_cnt, 1);
    chk("postreset_latency", stb_edge, c_DEB + 2);
    chk("postreset_acc",   int'(bus.acc),   'h03);
    chk("postreset_carry", int'(bus.carry), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
